// File: rtl/control_seq.sv
// Instruction sequencer/decoder for the DSP48 PE array: repeats each accepted
// instruction rpt+1 times, decodes per-lane DSP controls and tracks write-back.
module control_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int INST_WIDTH = 64,
  parameter int LANES      = 4,
  parameter int WB_DELAY   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inst_v,
  input  logic [INST_WIDTH-1:0]   inst,
  output logic                    inst_rdy,
  output logic                    busy,
  input  logic                    din_ld_v,
  input  logic [2*DATA_WIDTH-1:0] din_ld,
  input  logic [2*DATA_WIDTH-1:0] din_wb,
  output logic                    dout_v,
  output logic [2*DATA_WIDTH-1:0] dout,
  output logic                    ld_drop,
  output logic [4*LANES-1:0]      alumode,
  output logic [5*LANES-1:0]      inmode,
  output logic [7*LANES-1:0]      opmode,
  output logic [LANES-1:0]        cea2,
  output logic [LANES-1:0]        ceb2,
  output logic [LANES-1:0]        usemult
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                  state_q;
  logic [4:0]              cnt_q;
  logic [2:0]              opc_q;
  logic [LANES-1:0]        mask_q;
  logic [WB_DELAY-1:0]     wb_sr_q;
  logic [2*DATA_WIDTH-1:0] dout_q;
  logic                    ld_drop_q;

  logic [4*LANES-1:0] alumode_d, alumode_q;
  logic [5*LANES-1:0] inmode_d, inmode_q;
  logic [7*LANES-1:0] opmode_d, opmode_q;
  logic [LANES-1:0]   cea2_d, cea2_q;
  logic [LANES-1:0]   ceb2_d, ceb2_q;
  logic [LANES-1:0]   usemult_d, usemult_q;

  logic accept;
  logic issue;
  logic unused_inst;

  assign inst_rdy    = (state_q == IDLE) || (cnt_q == 5'd0);
  assign busy        = (state_q == ISSUE);
  assign issue       = busy;
  assign accept      = inst_v && inst_rdy;
  assign unused_inst = ^{inst[INST_WIDTH-1:32], inst[23:LANES]};

  // A new accept while the last repeat is issuing reloads without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      opc_q   <= 3'd0;
      mask_q  <= '0;
    end else if (accept) begin
      state_q <= ISSUE;
      cnt_q   <= inst[28:24];
      opc_q   <= inst[31:29];
      mask_q  <= inst[LANES-1:0];
    end else if (state_q == ISSUE) begin
      if (cnt_q != 5'd0) begin
        cnt_q <= cnt_q - 5'd1;
      end else begin
        state_q <= IDLE;
      end
    end
  end

  always_comb begin
    alumode_d = '0;
    inmode_d  = '0;
    opmode_d  = '0;
    cea2_d    = '0;
    ceb2_d    = '0;
    usemult_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (issue && mask_q[i]) begin
        case (opc_q)
          3'b001, 3'b010: begin
            opmode_d[7*i +: 7] = 7'b0110011;
            cea2_d[i]          = 1'b1;
            ceb2_d[i]          = 1'b1;
            if (opc_q == 3'b010) alumode_d[4*i +: 4] = 4'b0011;
          end
          3'b100, 3'b111: begin
            inmode_d[5*i +: 5] = 5'b10001;
            opmode_d[7*i +: 7] = 7'b0000101;
            usemult_d[i]       = 1'b1;
          end
          // Odd lanes carry the second product term of the fused pair.
          3'b101, 3'b110: begin
            opmode_d[7*i +: 7] = 7'b0110011;
            usemult_d[i]       = 1'b1;
            if (i % 2 == 1) begin
              inmode_d[5*i +: 5] = 5'b10001;
              if (opc_q == 3'b110) alumode_d[4*i +: 4] = 4'b0011;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alumode_q <= '0;
      inmode_q  <= '0;
      opmode_q  <= '0;
      cea2_q    <= '0;
      ceb2_q    <= '0;
      usemult_q <= '0;
      wb_sr_q   <= '0;
      dout_q    <= '0;
      ld_drop_q <= 1'b0;
    end else begin
      alumode_q <= alumode_d;
      inmode_q  <= inmode_d;
      opmode_q  <= opmode_d;
      cea2_q    <= cea2_d;
      ceb2_q    <= ceb2_d;
      usemult_q <= usemult_d;
      wb_sr_q   <= {wb_sr_q[WB_DELAY-2:0], issue};
      // Write-back owns the bus; a coincident load is lost and flagged.
      if (dout_v) begin
        dout_q <= din_wb;
      end else if (din_ld_v) begin
        dout_q <= din_ld;
      end
      ld_drop_q <= dout_v && din_ld_v;
    end
  end

  assign dout_v  = wb_sr_q[WB_DELAY-1];
  assign dout    = dout_q;
  assign ld_drop = ld_drop_q;
  assign alumode = alumode_q;
  assign inmode  = inmode_q;
  assign opmode  = opmode_q;
  assign cea2    = cea2_q;
  assign ceb2    = ceb2_q;
  assign usemult = usemult_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_control_seq;

  localparam int DW = 16;
  localparam int IW = 64;
  localparam int LN = 4;
  localparam int WB = 6;

  typedef struct packed {
    logic [15:0] alu;
    logic [19:0] inm;
    logic [27:0] opm;
    logic [3:0]  cea;
    logic [3:0]  ceb;
    logic [3:0]  um;
  } ctl_t;

  typedef struct {
    int   cyc;
    ctl_t ctl;
  } ctlExp_t;

  logic          clk;
  logic          rst;
  logic          inst_v;
  logic [IW-1:0] inst;
  logic          inst_rdy;
  logic          busy;
  logic          din_ld_v;
  logic [31:0]   din_ld;
  logic [31:0]   din_wb;
  logic          dout_v;
  logic [31:0]   dout;
  logic          ld_drop;
  logic [15:0]   alumode;
  logic [19:0]   inmode;
  logic [27:0]   opmode;
  logic [3:0]    cea2;
  logic [3:0]    ceb2;
  logic [3:0]    usemult;

  int      cyc = 0;
  int      vecCount = 0;
  int      missCount = 0;
  int      lastIssue = 0;
  bit      monitorOn = 0;
  ctlExp_t ctlQ[$];
  int      dvQ[$];
  int      issueQ[$];

  control_seq #(
    .DATA_WIDTH(DW), .INST_WIDTH(IW), .LANES(LN), .WB_DELAY(WB)
  ) dut (
    .clk(clk), .rst(rst), .inst_v(inst_v), .inst(inst), .inst_rdy(inst_rdy),
    .busy(busy), .din_ld_v(din_ld_v), .din_ld(din_ld), .din_wb(din_wb),
    .dout_v(dout_v), .dout(dout), .ld_drop(ld_drop), .alumode(alumode),
    .inmode(inmode), .opmode(opmode), .cea2(cea2), .ceb2(ceb2), .usemult(usemult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ctl_t mk(input logic [15:0] alu, input logic [19:0] inm,
                              input logic [27:0] opm, input logic [3:0] cea,
                              input logic [3:0] ceb, input logic [3:0] um);
    ctl_t c;
    c.alu = alu; c.inm = inm; c.opm = opm; c.cea = cea; c.ceb = ceb; c.um = um;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one instruction, holding it until the model says it is taken;
  // k returns the accepting edge number.
  task automatic applyStimulus(input logic [2:0] opc, input logic [4:0] rpt,
                               input logic [3:0] mask, input ctl_t exp,
                               output int k);
    bit taken;
    int tries;
    taken = 0;
    tries = 0;
    k = 0;
    inst   = {32'hA5A5_5A5A, opc, rpt, 20'hFFFFF, mask};
    inst_v = 1'b1;
    while (!taken && tries < 100) begin
      checkOutput("inst_rdy", {127'd0, inst_rdy}, {127'd0, cyc >= lastIssue});
      if (cyc >= lastIssue) begin
        taken = 1;
        k = cyc + 1;
        for (int j = 0; j <= int'(rpt); j++) begin
          issueQ.push_back(k + j);
          ctlQ.push_back('{cyc: k + j + 1, ctl: exp});
          dvQ.push_back(k + j + WB);
        end
        lastIssue = k + int'(rpt);
      end
      tries++;
      @(posedge clk);
      #1;
    end
    if (!taken) checkOutput("accept_timeout", 128'd0, 128'd1);
    inst_v = 1'b0;
  endtask

  // Every cycle: controls, busy and dout_v must match the scoreboard head
  // stamped for this cycle, or be zero when nothing is due.
  always @(negedge clk) begin
    if (monitorOn) begin
      ctl_t act;
      ctl_t exp;
      bit   dvExp;
      bit   busyExp;
      exp = '0;
      if (ctlQ.size() > 0 && ctlQ[0].cyc == cyc) begin
        exp = ctlQ[0].ctl;
        void'(ctlQ.pop_front());
      end
      dvExp = 0;
      if (dvQ.size() > 0 && dvQ[0] == cyc) begin
        dvExp = 1;
        void'(dvQ.pop_front());
      end
      busyExp = 0;
      if (issueQ.size() > 0 && issueQ[0] == cyc) begin
        busyExp = 1;
        void'(issueQ.pop_front());
      end
      act = {alumode, inmode, opmode, cea2, ceb2, usemult};
      checkOutput("controls", {52'd0, act}, {52'd0, exp});
      checkOutput("dout_v", {127'd0, dout_v}, {127'd0, dvExp});
      checkOutput("busy", {127'd0, busy}, {127'd0, busyExp});
    end
  end

  initial begin
    int k;
    rst = 1'b1; inst_v = 1'b0; inst = '0;
    din_ld_v = 1'b0; din_ld = '0; din_wb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    monitorOn = 1;
    lastIssue = cyc;
    checkOutput("rst_inst_rdy", {127'd0, inst_rdy}, 128'd1);
    checkOutput("rst_dout", {96'd0, dout}, 128'd0);
    checkOutput("rst_ld_drop", {127'd0, ld_drop}, 128'd0);
    idle(10);

    // ADD, then load/write-back collision on its dout_v cycle
    applyStimulus(3'b001, 5'd0, 4'hF, mk(16'h0, 20'h0, {4{7'b0110011}}, 4'hF, 4'hF, 4'h0), k);
    while (cyc < k + WB) idle(1);
    din_wb = 32'h1234_5678; din_ld = 32'hAAAA_5555; din_ld_v = 1'b1;
    idle(1);
    din_ld_v = 1'b0;
    checkOutput("collide_dout", {96'd0, dout}, {96'd0, 32'h1234_5678});
    checkOutput("collide_ld_drop", {127'd0, ld_drop}, 128'd1);
    idle(1);
    checkOutput("ld_drop_pulse", {127'd0, ld_drop}, 128'd0);
    checkOutput("dout_hold", {96'd0, dout}, {96'd0, 32'h1234_5678});
    din_wb = 32'hDEAD_BEEF; din_ld_v = 1'b1;
    idle(1);
    din_ld_v = 1'b0;
    checkOutput("load_dout", {96'd0, dout}, {96'd0, 32'hAAAA_5555});
    checkOutput("load_no_drop", {127'd0, ld_drop}, 128'd0);
    idle(1);
    checkOutput("load_hold", {96'd0, dout}, {96'd0, 32'hAAAA_5555});
    idle(4);

    applyStimulus(3'b110, 5'd3, 4'hF,
      mk(16'h3030, 20'b10001_00000_10001_00000, {4{7'b0110011}}, 4'h0, 4'h0, 4'hF), k);
    idle(8);

    applyStimulus(3'b100, 5'd1, 4'hF,
      mk(16'h0, {4{5'b10001}}, {4{7'b0000101}}, 4'h0, 4'h0, 4'hF), k);
    applyStimulus(3'b010, 5'd0, 4'hF,
      mk(16'h3333, 20'h0, {4{7'b0110011}}, 4'hF, 4'hF, 4'h0), k);
    idle(8);

    applyStimulus(3'b100, 5'd0, 4'h5,
      mk(16'h0, 20'b00000_10001_00000_10001,
         {7'b0, 7'b0000101, 7'b0, 7'b0000101}, 4'h0, 4'h0, 4'h5), k);
    applyStimulus(3'b111, 5'd0, 4'h3,
      mk(16'h0, 20'b00000_00000_10001_10001,
         {14'b0, 7'b0000101, 7'b0000101}, 4'h0, 4'h0, 4'h3), k);
    applyStimulus(3'b011, 5'd1, 4'hF, '0, k);
    applyStimulus(3'b000, 5'd0, 4'hF, '0, k);
    applyStimulus(3'b101, 5'd31, 4'hF,
      mk(16'h0, 20'b10001_00000_10001_00000, {4{7'b0110011}}, 4'h0, 4'h0, 4'hF), k);
    idle(45);

    // Abort a long MUL part-way through its repeats
    applyStimulus(3'b100, 5'd7, 4'hF,
      mk(16'h0, {4{5'b10001}}, {4{7'b0000101}}, 4'h0, 4'h0, 4'hF), k);
    idle(3);
    rst = 1'b1;
    while (ctlQ.size() > 0 && ctlQ[$].cyc > cyc) void'(ctlQ.pop_back());
    while (dvQ.size() > 0 && dvQ[$] > cyc) void'(dvQ.pop_back());
    while (issueQ.size() > 0 && issueQ[$] > cyc) void'(issueQ.pop_back());
    lastIssue = cyc;
    idle(1);
    checkOutput("midrst_dout", {96'd0, dout}, 128'd0);
    checkOutput("midrst_ld_drop", {127'd0, ld_drop}, 128'd0);
    checkOutput("midrst_inst_rdy", {127'd0, inst_rdy}, 128'd1);
    idle(1);
    rst = 1'b0;
    idle(12);
    checkOutput("post_rst_dout", {96'd0, dout}, 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
